// File: rtl/adc_spi_sampler.sv
// SPI ADC front end: clocks one conversion frame per sample period out of the ADC
// and queues the captured codes in a show-ahead FIFO for the CNN sample input.
module adc_spi_sampler #(
   parameter int ADC_WIDTH     = 12,
   parameter int FRAME_BITS    = 16,
   parameter int SCLK_DIV      = 2,
   parameter int SAMPLE_PERIOD = 100,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enable,
   output logic                             adc_cs_n,
   output logic                             adc_sclk,
   input  logic                             adc_miso,
   input  logic                             sampler_ready_out,
   output logic                             sampler_valid_out,
   output logic [ADC_WIDTH-1:0]             sampler_data_out,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
   output logic                             overflow,
   input  logic                             clear_overflow
);

   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

   if (SAMPLE_PERIOD < 2 * SCLK_DIV * (FRAME_BITS + 1) + 2) begin : g_bad_period
      $error("adc_spi_sampler: SAMPLE_PERIOD too short for one SPI frame");
   end
   if (FRAME_BITS < ADC_WIDTH || SCLK_DIV < 1) begin : g_bad_frame
      $error("adc_spi_sampler: FRAME_BITS must cover ADC_WIDTH and SCLK_DIV must be >= 1");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("adc_spi_sampler: FIFO_DEPTH must be a power of 2, at least 2");
   end

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

   state_t                 state;
   logic [TW-1:0]          timer;
   logic [CW-1:0]          div_cnt;
   logic [BW-1:0]          bit_cnt;
   logic [ADC_WIDTH-1:0]   shreg;
   logic [ADC_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic                   push;
   logic                   pop;
   logic                   drop;
   logic                   wr_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer <= '0;
      end else if (!enable || timer == TW'(SAMPLE_PERIOD - 1)) begin
         timer <= '0;
      end else begin
         timer <= timer + TW'(1);
      end
   end

   // Only the last ADC_WIDTH bits of the frame are kept, so a narrow shift register suffices.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         adc_cs_n <= 1'b1;
         adc_sclk <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable && timer == '0) begin
                  adc_cs_n <= 1'b0;
                  div_cnt  <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (div_cnt == CW'(SCLK_DIV - 1)) begin
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  adc_sclk <= 1'b1;
                  shreg    <= {shreg[ADC_WIDTH-2:0], adc_miso};
                  state    <= SHIFT;
               end else begin
                  div_cnt <= div_cnt + CW'(1);
               end
            end
            SHIFT: begin
               if (div_cnt == CW'(SCLK_DIV - 1)) begin
                  div_cnt <= '0;
                  if (adc_sclk) begin
                     adc_sclk <= 1'b0;
                  end else if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                     adc_cs_n <= 1'b1;
                     state    <= DONE;
                  end else begin
                     adc_sclk <= 1'b1;
                     shreg    <= {shreg[ADC_WIDTH-2:0], adc_miso};
                     bit_cnt  <= bit_cnt + BW'(1);
                  end
               end else begin
                  div_cnt <= div_cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign push              = (state == DONE);
   assign sampler_valid_out = (fifo_level != '0);
   assign pop               = sampler_valid_out && sampler_ready_out;
   assign drop              = push && (fifo_level == LW'(FIFO_DEPTH)) && !pop;
   assign wr_en             = push && !drop;
   assign sampler_data_out  = sampler_valid_out ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= shreg;
      end
   end

   // A drop in the same cycle as clear_overflow must leave the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({wr_en, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end else if (clear_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: serial ADC model, per-cycle queue-based FIFO model,
// table-driven single frames, directed corner sequences and a randomized soak.
module tb_adc_spi_sampler;

   localparam int ADC_WIDTH  = 12;
   localparam int FIFO_DEPTH = 8;

   logic                  clk;
   logic                  rst;
   logic                  enable;
   logic                  adc_cs_n;
   logic                  adc_sclk;
   logic                  adc_miso;
   logic                  sampler_ready_out;
   logic                  sampler_valid_out;
   logic [ADC_WIDTH-1:0]  sampler_data_out;
   logic [3:0]            fifo_level;
   logic                  overflow;
   logic                  clear_overflow;

   int tests_run    = 0;
   int tests_failed = 0;

   adc_spi_sampler #(
      .ADC_WIDTH(12), .FRAME_BITS(16), .SCLK_DIV(2), .SAMPLE_PERIOD(100), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .adc_cs_n(adc_cs_n),
      .adc_sclk(adc_sclk),
      .adc_miso(adc_miso),
      .sampler_ready_out(sampler_ready_out),
      .sampler_valid_out(sampler_valid_out),
      .sampler_data_out(sampler_data_out),
      .fifo_level(fifo_level),
      .overflow(overflow),
      .clear_overflow(clear_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ADC model: a new word is latched when chip select falls, MSB first, next bit after each SCLK fall.
   logic [15:0] adc_q[$];
   logic [11:0] frame_q[$];
   logic [15:0] cur_word;
   int          bit_idx;
   bit          in_frame = 1'b0;

   initial adc_miso = 1'b0;
   always @(negedge adc_cs_n or posedge adc_cs_n or negedge adc_sclk) begin
      if (adc_cs_n) begin
         in_frame = 1'b0;
      end else if (!in_frame) begin
         in_frame = 1'b1;
         if (adc_q.size() > 0) cur_word = adc_q.pop_front();
         else cur_word = 16'($urandom);
         frame_q.push_back(cur_word[11:0]);
         bit_idx  = 15;
         adc_miso = cur_word[15];
      end else if (bit_idx > 0) begin
         bit_idx  = bit_idx - 1;
         adc_miso = cur_word[bit_idx];
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor plus reference model: the FIFO is a plain queue of up to 8 samples fed by completed frames.
   logic [11:0] model_q[$];
   logic [11:0] popped[$];
   int          pop_cycles[$];
   int          fall_cycles[$];
   bit          model_ovf = 1'b0;
   bit          prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0;
   int          cyc = 0, fall_count = 0, rise_count = 0;
   int          cur_low = 0, cur_sclk = 0, last_low = 0, last_sclk = 0;
   int          cs_rise_cyc = 0, valid_rise_cyc = 0;

   always @(negedge clk) begin
      logic [31:0] act_state, exp_state;
      logic [11:0] head, sample;
      bit          push, pop, full;
      cyc++;
      if (rst) begin
         model_q.delete();
         frame_q.delete();
         model_ovf  = 1'b0;
         prev_cs    = 1'b1;
         prev_sclk  = 1'b0;
         prev_valid = 1'b0;
         cur_low    = 0;
         cur_sclk   = 0;
      end else begin
         head      = (model_q.size() > 0) ? model_q[0] : 12'h000;
         act_state = {14'b0, sampler_valid_out, overflow, fifo_level, sampler_data_out};
         exp_state = {14'b0, model_q.size() > 0, model_ovf, 4'(model_q.size()), head};
         check_output("model_state", act_state, exp_state);

         if (!adc_cs_n) begin
            if (prev_cs) begin
               fall_count++;
               fall_cycles.push_back(cyc);
               cur_low  = 0;
               cur_sclk = 0;
            end
            cur_low++;
            if (adc_sclk && !prev_sclk) cur_sclk++;
         end
         push = adc_cs_n && !prev_cs;
         if (push) begin
            rise_count++;
            cs_rise_cyc = cyc;
            last_low    = cur_low;
            last_sclk   = cur_sclk;
         end
         if (sampler_valid_out && !prev_valid) valid_rise_cyc = cyc;
         if (sampler_valid_out && sampler_ready_out) begin
            popped.push_back(sampler_data_out);
            pop_cycles.push_back(cyc);
         end

         full = (model_q.size() == FIFO_DEPTH);
         pop  = (model_q.size() > 0) && sampler_ready_out;
         if (pop) void'(model_q.pop_front());
         if (push) begin
            sample = (frame_q.size() > 0) ? frame_q.pop_front() : 12'h000;
            if (full && !pop) model_ovf = 1'b1;
            else model_q.push_back(sample);
         end
         if (!(push && full && !pop) && clear_overflow) model_ovf = 1'b0;

         prev_cs    = adc_cs_n;
         prev_sclk  = adc_sclk;
         prev_valid = sampler_valid_out;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_stimulus(input logic en, input logic rdy, input logic clr);
      enable            = en;
      sampler_ready_out = rdy;
      clear_overflow    = clr;
   endtask

   task automatic wait_rises(input int target, input int budget, input string name);
      int n = 0;
      while (rise_count < target && n < budget) begin
         tick(1);
         n++;
      end
      check_output({name, "_frame_done"}, 32'(rise_count >= target), 32'd1);
   endtask

   typedef struct {
      logic [15:0] word;
      logic [11:0] exp_data;
   } vec_t;
   vec_t vecs[5];

   initial begin
      int base, base_fall, n, mode;
      vecs[0] = '{16'h0ABC, 12'hABC};
      vecs[1] = '{16'hFFFF, 12'hFFF};
      vecs[2] = '{16'h0000, 12'h000};
      vecs[3] = '{16'hF123, 12'h123};
      vecs[4] = '{16'h8001, 12'h001};

      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b0);
      #12;
      check_output("rst_cs_n", 32'(adc_cs_n), 32'd1);
      check_output("rst_sclk", 32'(adc_sclk), 32'd0);
      check_output("rst_valid", 32'(sampler_valid_out), 32'd0);
      check_output("rst_data", 32'(sampler_data_out), 32'd0);
      check_output("rst_level", 32'(fifo_level), 32'd0);
      check_output("rst_overflow", 32'(overflow), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick(2);

      for (int i = 0; i < 5; i++) begin
         base = rise_count;
         adc_q.push_back(vecs[i].word);
         apply_stimulus(1'b1, 1'b0, 1'b0);
         tick(1);
         apply_stimulus(1'b0, 1'b0, 1'b0);
         wait_rises(base + 1, 150, "vec");
         tick(3);
         check_output($sformatf("vec%0d_data", i), 32'(sampler_data_out), 32'(vecs[i].exp_data));
         check_output($sformatf("vec%0d_cs_low", i), 32'(last_low), 32'd66);
         check_output($sformatf("vec%0d_sclk_rises", i), 32'(last_sclk), 32'd16);
         check_output($sformatf("vec%0d_valid_latency", i), 32'(valid_rise_cyc - cs_rise_cyc), 32'd1);
         apply_stimulus(1'b0, 1'b1, 1'b0);
         tick(1);
         apply_stimulus(1'b0, 1'b0, 1'b0);
         check_output($sformatf("vec%0d_level_after_pop", i), 32'(fifo_level), 32'd0);
      end

      // Continuous sampling: 1000 enabled edges give ten frames 100 cycles apart.
      fall_cycles.delete();
      popped.delete();
      for (int v = 1; v <= 10; v++) adc_q.push_back(16'(v));
      apply_stimulus(1'b1, 1'b1, 1'b0);
      tick(1000);
      apply_stimulus(1'b0, 1'b1, 1'b0);
      tick(150);
      check_output("period_frames", 32'(fall_cycles.size()), 32'd10);
      for (int i = 1; i < 10; i++)
         check_output($sformatf("period_%0d", i),
                      32'((i < fall_cycles.size()) ? fall_cycles[i] - fall_cycles[i-1] : -1), 32'd100);
      for (int i = 0; i < 10; i++)
         check_output($sformatf("stream_%0d", i),
                      (i < popped.size()) ? 32'(popped[i]) : 32'hFFFF, 32'(i + 1));

      // Back-pressure: nine frames into an eight-deep buffer.
      apply_stimulus(1'b0, 1'b0, 1'b0);
      popped.delete();
      pop_cycles.delete();
      base = rise_count;
      for (int v = 1; v <= 9; v++) adc_q.push_back(16'(v));
      apply_stimulus(1'b1, 1'b0, 1'b0);
      wait_rises(base + 8, 900, "ovf_fill");
      tick(3);
      check_output("ovf_level8", 32'(fifo_level), 32'd8);
      check_output("ovf_not_yet", 32'(overflow), 32'd0);
      wait_rises(base + 9, 200, "ovf_ninth");
      apply_stimulus(1'b0, 1'b0, 1'b0);
      tick(3);
      check_output("ovf_level_held", 32'(fifo_level), 32'd8);
      check_output("ovf_set", 32'(overflow), 32'd1);
      apply_stimulus(1'b0, 1'b1, 1'b0);
      tick(12);
      check_output("drain_count", 32'(popped.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         check_output($sformatf("drain_%0d", i),
                      (i < popped.size()) ? 32'(popped[i]) : 32'hFFFF, 32'(i + 1));
      check_output("drain_back_to_back",
                   32'((pop_cycles.size() == 8) ? pop_cycles[7] - pop_cycles[0] : -1), 32'd7);
      check_output("ovf_sticky", 32'(overflow), 32'd1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      tick(1);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("ovf_cleared", 32'(overflow), 32'd0);

      // Full buffer, ready only in the push cycle: push and pop both accepted.
      base = rise_count;
      for (int v = 11; v <= 18; v++) adc_q.push_back(16'(v));
      apply_stimulus(1'b1, 1'b0, 1'b0);
      wait_rises(base + 8, 900, "full_fill");
      apply_stimulus(1'b0, 1'b0, 1'b0);
      tick(3);
      check_output("full_level", 32'(fifo_level), 32'd8);
      adc_q.push_back(16'd19);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      tick(1);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      n = 0;
      while (!adc_cs_n && n < 200) begin
         tick(1);
         n++;
      end
      check_output("full_cs_rise_seen", 32'(adc_cs_n), 32'd1);
      popped.delete();
      apply_stimulus(1'b0, 1'b1, 1'b0);
      tick(1);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      tick(2);
      check_output("full_level_kept", 32'(fifo_level), 32'd8);
      check_output("full_no_overflow", 32'(overflow), 32'd0);
      check_output("full_new_head", 32'(sampler_data_out), 32'd12);
      apply_stimulus(1'b0, 1'b1, 1'b0);
      tick(12);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++)
         check_output($sformatf("full_order_%0d", i),
                      (i < popped.size()) ? 32'(popped[i]) : 32'hFFFF, 32'(i + 11));

      // Enable dropped at SCLK bit 5: the frame still completes in full.
      base      = rise_count;
      base_fall = fall_count;
      adc_q.push_back(16'h0777);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      n = 0;
      while (!(fall_count > base_fall && cur_sclk >= 5) && n < 100) begin
         tick(1);
         n++;
      end
      apply_stimulus(1'b0, 1'b0, 1'b0);
      wait_rises(base + 1, 200, "drop_en");
      tick(200);
      check_output("drop_en_one_frame", 32'(fall_count - base_fall), 32'd1);
      check_output("drop_en_sclk_rises", 32'(last_sclk), 32'd16);
      check_output("drop_en_cs_low", 32'(last_low), 32'd66);
      check_output("drop_en_level", 32'(fifo_level), 32'd1);
      check_output("drop_en_data", 32'(sampler_data_out), 32'h777);
      apply_stimulus(1'b0, 1'b1, 1'b0);
      tick(2);
      apply_stimulus(1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a shift with three samples buffered.
      base = rise_count;
      for (int v = 0; v < 5; v++) adc_q.push_back(16'(16'h0101 + v));
      apply_stimulus(1'b1, 1'b0, 1'b0);
      wait_rises(base + 3, 400, "rst_fill");
      base_fall = fall_count;
      n = 0;
      while (!(fall_count > base_fall && cur_sclk >= 3) && n < 200) begin
         tick(1);
         n++;
      end
      check_output("rst_pre_level", 32'(fifo_level), 32'd3);
      check_output("rst_pre_in_frame", 32'(adc_cs_n), 32'd0);
      rst = 1'b1;
      #1;
      check_output("async_cs_n", 32'(adc_cs_n), 32'd1);
      check_output("async_sclk", 32'(adc_sclk), 32'd0);
      check_output("async_valid", 32'(sampler_valid_out), 32'd0);
      check_output("async_level", 32'(fifo_level), 32'd0);
      check_output("async_data", 32'(sampler_data_out), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      base = rise_count;
      wait_rises(base + 1, 200, "rst_restart");
      apply_stimulus(1'b0, 1'b0, 1'b0);
      tick(3);
      check_output("restart_level", 32'(fifo_level), 32'd1);
      check_output("restart_data", 32'(sampler_data_out), 32'h105);
      check_output("restart_cs_low", 32'(last_low), 32'd66);
      check_output("restart_sclk_rises", 32'(last_sclk), 32'd16);
      apply_stimulus(1'b0, 1'b1, 1'b0);
      tick(2);

      // Randomized soak: random enable, ready patterns and clears, checked by the model every cycle.
      enable = 1'b1;
      for (int blk = 0; blk < 20; blk++) begin
         mode = $urandom_range(0, 2);
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 99) < 3) enable = ~enable;
            sampler_ready_out = (mode == 0) ? 1'b0 :
                                (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            clear_overflow = ($urandom_range(0, 49) == 0);
            tick(1);
         end
      end
      apply_stimulus(1'b0, 1'b1, 1'b0);
      tick(150);
      check_output("soak_drained", 32'(fifo_level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/adc_spi_sampler.md
# adc_spi_sampler

Front-end stage that produces the CNN's raw ADC sample stream. It clocks conversion frames out of an external SPI ADC at a fixed sample rate and buffers the captured codes in a small show-ahead FIFO. Its valid/ready/data output feeds the CNN top-level sample input (`cnn_valid_in` / `cnn_ready_in` / `cnn_data_in`), upstream of the subsample stage. It also reports overflow when the CNN back-pressures longer than the FIFO can absorb.

## Interface

Parameters:
- `ADC_WIDTH`, default `cnn1d_pkg::ADC_WIDTH`: width of the returned sample code.
- `FRAME_BITS`, default 16: SCLK bits per frame; must be ≥ `ADC_WIDTH`.
- `SCLK_DIV`, default 2: clk cycles per SCLK half-period; must be ≥ 1.
- `SAMPLE_PERIOD`, default 100: clk cycles between frame starts; must be ≥ 2·`SCLK_DIV`·(`FRAME_BITS`+1)+2. This is an elaboration-time check.
- `FIFO_DEPTH`, default 8: sample buffer depth; power of 2, ≥ 2.

Ports:
- `clk`, input, 1: sole clock.
- `rst`, input, 1: reset; **asynchronous, active-high**.
- `enable`, input, 1: run the sample timer and start frames.
- `adc_cs_n`, output, 1: ADC chip select, active low, registered.
- `adc_sclk`, output, 1: SPI clock, idle low, registered.
- `adc_miso`, input, 1: ADC serial data; ADC updates it on the SCLK falling edge, MSB first.
- `sampler_ready_out`, input, 1: downstream ready.
- `sampler_valid_out`, output, 1: FIFO non-empty.
- `sampler_data_out`, output, `ADC_WIDTH`: FIFO head sample.
- `fifo_level`, output, $clog2(`FIFO_DEPTH`+1): current occupancy.
- `overflow`, output, 1: sticky; set when a sample is dropped.
- `clear_overflow`, input, 1: synchronous clear of `overflow`.

## Operation

- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `sampler_valid_out`=0, `sampler_data_out`=0, `fifo_level`=0, `overflow`=0. Reset also clears the FSM to IDLE, zeroes the timer and empties the FIFO.
- Sample timer:
  - Counts 0..`SAMPLE_PERIOD`-1 and wraps while `enable`=1.
  - Forced to 0 while `enable`=0.
  - A frame starts in IDLE when `enable`=1 and timer=0. Frames are therefore exactly `SAMPLE_PERIOD` cycles apart.
- FSM states:
  - IDLE → SETUP: on start; `adc_cs_n`←0.
  - SETUP: `SCLK_DIV` cycles with `adc_sclk` low, then → SHIFT.
  - SHIFT: `FRAME_BITS` bits, each `SCLK_DIV` cycles high followed by `SCLK_DIV` cycles low.
    - `adc_miso` is captured into the shift register at the clock edge that drives `adc_sclk` 0→1.
    - After the low phase of the last bit → DONE.
  - DONE: one edge; `adc_cs_n`←1 and the captured word's last `ADC_WIDTH` bits are pushed to the FIFO; → IDLE.
- Deasserting `enable` mid-frame: the frame completes and pushes normally. No new frame starts.
- FIFO:
  - Show-ahead: `sampler_data_out` is the head, valid whenever level>0.
  - Pop on `sampler_valid_out && sampler_ready_out`.
  - Push with FIFO full and no pop in the same cycle: the sample is dropped, `overflow`←1, level unchanged.
  - Push and pop in the same cycle when full: both are accepted, no overflow.
  - Push and pop when empty: impossible, since valid is low.
- `overflow`: set takes priority over `clear_overflow` in the same cycle.
- Data is unsigned; no sign-extension. Pointers wrap modulo `FIFO_DEPTH`.

## Timing

- `adc_cs_n` low duration = `SCLK_DIV`·(2·`FRAME_BITS`+1) cycles; this is 66 at the defaults.
- Exactly `FRAME_BITS` SCLK rising edges occur per frame.
- Start latency: `adc_cs_n` falls at the first edge with `enable`=1 and timer=0, i.e. the first edge after `enable` rises.
- Push latency: `sampler_valid_out` and `fifo_level` update in the cycle after the DONE edge.
- Pop takes effect at the accepting edge; the next head appears in the following cycle. Full throughput is one pop per cycle.
- Async reset mid-frame: outputs take their reset values immediately, without waiting for a clock edge. A partial frame is discarded.

## Test plan

- Single frame, defaults, ADC model returns 16'h0ABC, `ADC_WIDTH`=12 → `adc_cs_n` low for 66 cycles, 16 SCLK rises, `sampler_data_out`=12'hABC, valid one cycle after `adc_cs_n` rises.
- `enable` held high for 1000 cycles → frame starts exactly 100 cycles apart, 10 samples pushed in order (values 1..10 from the model).
- `sampler_ready_out`=0 for 9 frames → `fifo_level`=8 after 8, 9th dropped, `overflow`=1. Then ready=1 → samples 1..8 drained back-to-back in order. `clear_overflow` pulse → `overflow`=0.
- FIFO full, ready=1 only in the cycle that coincides with a push → one pop and one push both accepted, level stays 8, `overflow` stays 0.
- `enable` dropped at SCLK bit 5 → frame completes with 16 bits, one sample pushed, no further `adc_cs_n` fall.
- `rst` asserted mid-SHIFT with 3 samples buffered → `adc_cs_n`=1, `adc_sclk`=0, valid=0, level=0 before the next clk edge. After release with `enable`=1, the next frame starts cleanly.
